// File: rtl/mac_job_issuer.sv
// Job issuer for the MAC sample controller: replays a small table of request words and captures results.
// Optional result checking against table[idx][31:24] is enabled by defining MAC_ISSUER_CHECK_EN.
module mac_job_issuer #(
    parameter int NUM_JOBS    = 8,
    parameter int ADDR_W      = 3,
    parameter int TIMEOUT_CYC = 64,
    parameter int GAP_CYC     = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [ADDR_W:0]   num_jobs,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              r_valid,
    output logic [31:0]       req_data,
    input  logic              t_valid,
    input  logic [7:0]        rsp_data,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_idx,
    output logic [7:0]        res_data,
    output logic              timeout_err,
    output logic [ADDR_W:0]   err_cnt
);

    localparam int JW    = ADDR_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [JW-1:0]    MAX_JOBS  = JW'(NUM_JOBS);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [JW-1:0]      jobs_q, jobs_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               issue_cnt_q, issue_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               r_valid_q, r_valid_d;
    logic [31:0]        req_data_q, req_data_d;
    logic               res_valid_q, res_valid_d;
    logic [ADDR_W-1:0]  res_idx_q, res_idx_d;
    logic [7:0]         res_data_q, res_data_d;
    logic               timeout_err_q, timeout_err_d;

    logic [31:0]        table_q [NUM_JOBS];
    logic [JW-1:0]      idx_plus;

    // Table contents survive reset; writes are only accepted while idle.
    always_ff @(posedge clk) begin
        if (ld_en && (state_q == IDLE)) begin
            table_q[ld_addr] <= ld_data;
        end
    end

    assign idx_plus = {1'b0, idx_q} + JW'(1);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        jobs_d        = jobs_q;
        wait_cnt_d    = wait_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        issue_cnt_d   = issue_cnt_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        r_valid_d     = 1'b0;
        req_data_d    = '0;
        res_valid_d   = 1'b0;
        res_idx_d     = res_idx_q;
        res_data_d    = res_data_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (num_jobs == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        jobs_d        = (num_jobs > MAX_JOBS) ? MAX_JOBS : num_jobs;
                        idx_d         = '0;
                        timeout_err_d = 1'b0;
                        issue_cnt_d   = 1'b0;
                        r_valid_d     = 1'b1;
                        req_data_d    = table_q[0];
                        state_d       = ISSUE;
                    end
                end
            end

            // r_valid is held for two cycles; the controller latches the word on the second.
            ISSUE: begin
                if (!issue_cnt_q) begin
                    issue_cnt_d = 1'b1;
                    r_valid_d   = 1'b1;
                    req_data_d  = req_data_q;
                end else begin
                    issue_cnt_d = 1'b0;
                    wait_cnt_d  = '0;
                    state_d     = WAIT;
                end
            end

            // A response on the final counted cycle wins over the timeout.
            WAIT: begin
                if (t_valid) begin
                    res_valid_d = 1'b1;
                    res_idx_d   = idx_q;
                    res_data_d  = rsp_data;
                    gap_cnt_d   = '0;
                    state_d     = GAP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    done_d        = 1'b1;
                    state_d       = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (idx_plus == jobs_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d       = idx_plus[ADDR_W-1:0];
                        issue_cnt_d = 1'b0;
                        r_valid_d   = 1'b1;
                        req_data_d  = table_q[idx_plus[ADDR_W-1:0]];
                        state_d     = ISSUE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            jobs_q        <= '0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            issue_cnt_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            r_valid_q     <= 1'b0;
            req_data_q    <= '0;
            res_valid_q   <= 1'b0;
            res_idx_q     <= '0;
            res_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            jobs_q        <= jobs_d;
            wait_cnt_q    <= wait_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            issue_cnt_q   <= issue_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            r_valid_q     <= r_valid_d;
            req_data_q    <= req_data_d;
            res_valid_q   <= res_valid_d;
            res_idx_q     <= res_idx_d;
            res_data_q    <= res_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign r_valid     = r_valid_q;
    assign req_data    = req_data_q;
    assign res_valid   = res_valid_q;
    assign res_idx     = res_idx_q;
    assign res_data    = res_data_q;
    assign timeout_err = timeout_err_q;

`ifdef MAC_ISSUER_CHECK_EN
    logic          capture;
    logic          err_clr;
    logic [JW-1:0] err_cnt_q, err_cnt_d;

    assign capture = (state_q == WAIT) && t_valid;
    assign err_clr = (state_q == IDLE) && start && (num_jobs != '0);

    // Saturating mismatch count, updated on the same edge that raises res_valid.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (capture && (rsp_data != table_q[idx_q][31:24]) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + JW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_job_issuer.sv
// Directed self-checking bench for mac_job_issuer with a built-in responder model.
module tb_mac_job_issuer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  num_jobs;
    logic        start;
    logic        busy;
    logic        done;
    logic        r_valid;
    logic [31:0] req_data;
    logic        t_valid;
    logic [7:0]  rsp_data;
    logic        res_valid;
    logic [2:0]  res_idx;
    logic [7:0]  res_data;
    logic        timeout_err;
    logic [3:0]  err_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  rsp_tab [8];
    bit          busy_load = 1'b0;
    logic [31:0] busy_load_data = '0;

    int          obs_rv_len[$];
    logic [31:0] obs_req[$];
    int          obs_res_idx[$];
    logic [7:0]  obs_res_data[$];
    bit          obs_req_stable;
    int          obs_done;
    int          obs_done_cyc;
    int          obs_min_gap;
    int          obs_timeout_wait;
    bit          obs_finished;
    logic        obs_timeout;
    logic        obs_tv_at_issue;
    logic [3:0]  obs_err_at_done;
    logic        obs_busy_after;

    mac_job_issuer #(
        .NUM_JOBS(8),
        .ADDR_W(3),
        .TIMEOUT_CYC(64),
        .GAP_CYC(2)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .ld_en(ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .num_jobs(num_jobs),
        .start(start),
        .busy(busy),
        .done(done),
        .r_valid(r_valid),
        .req_data(req_data),
        .t_valid(t_valid),
        .rsp_data(rsp_data),
        .res_valid(res_valid),
        .res_idx(res_idx),
        .res_data(res_data),
        .timeout_err(timeout_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic load(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Starts a run and plays the controller: t_valid 10 cycles after the second r_valid cycle.
    task automatic run_jobs(input int n, input bit respond);
        int  since;
        int  jobs_issued;
        int  last_res;
        bit  prev_rv;
        bit  done_prev;
        obs_rv_len.delete();
        obs_req.delete();
        obs_res_idx.delete();
        obs_res_data.delete();
        obs_req_stable = 1'b1;
        obs_done = 0;
        obs_done_cyc = -1;
        obs_min_gap = 1000;
        obs_timeout_wait = -1;
        obs_finished = 1'b0;
        obs_timeout = 1'b0;
        obs_tv_at_issue = 1'bx;
        obs_err_at_done = 'x;
        obs_busy_after = 1'b1;
        since = 0;
        jobs_issued = 0;
        last_res = -1;
        prev_rv = 1'b0;
        done_prev = 1'b0;
        num_jobs = 4'(n);
        start = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (busy) start = 1'b0;
            t_valid = 1'b0;
            rsp_data = 8'h00;
            ld_en = 1'b0;
            if (done_prev) begin
                obs_busy_after = busy;
                obs_done += int'(done);
                obs_finished = 1'b1;
                break;
            end
            if (r_valid) begin
                if (!prev_rv) begin
                    obs_rv_len.push_back(1);
                    obs_req.push_back(req_data);
                    jobs_issued++;
                    if (jobs_issued == 1) obs_tv_at_issue = timeout_err;
                    if (last_res >= 0 && (cyc - last_res) < obs_min_gap) obs_min_gap = cyc - last_res;
                end else begin
                    obs_rv_len[obs_rv_len.size()-1]++;
                    if (req_data !== obs_req[obs_req.size()-1]) obs_req_stable = 1'b0;
                end
                since = 0;
            end else if (prev_rv || since > 0) begin
                since++;
            end
            if (timeout_err === 1'b1 && obs_timeout_wait < 0 && since > 0) obs_timeout_wait = since - 1;
            if (res_valid) begin
                obs_res_idx.push_back(int'(res_idx));
                obs_res_data.push_back(res_data);
                last_res = cyc;
            end
            if (done) begin
                obs_done++;
                if (obs_done_cyc < 0) obs_done_cyc = cyc;
                obs_err_at_done = err_cnt;
                obs_timeout = timeout_err;
                done_prev = 1'b1;
            end
            if (respond && since == 10 && jobs_issued > 0) begin
                t_valid = 1'b1;
                rsp_data = rsp_tab[jobs_issued-1];
            end
            if (busy_load && cyc == 3) begin
                ld_en = 1'b1;
                ld_addr = 3'd0;
                ld_data = busy_load_data;
            end
            prev_rv = r_valid;
        end
        start = 1'b0;
        t_valid = 1'b0;
        ld_en = 1'b0;
    endtask

    task automatic test_reset;
        logic [51:0] outs;
        rstn = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        num_jobs = '0;
        start = 1'b0;
        t_valid = 1'b0;
        rsp_data = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            outs = {busy, done, r_valid, req_data, res_valid, res_idx, res_data, timeout_err, err_cnt};
            tests_run++;
            if (outs !== 52'h0) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
    endtask

    task automatic test_single_job;
        load(3'd0, 32'h1A_04_03_02);
        rsp_tab[0] = 8'h1A;
        run_jobs(1, 1'b1);
        tests_run++;
        if (obs_finished !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_finish: run did not end within budget");
        end
        tests_run++;
        if (obs_rv_len.size() != 1 || obs_rv_len[0] != 2) begin
            tests_failed++;
            $display("[TB] FAIL single_rvalid_len: issues=%0d first_len=%0d expected 1 issue of 2 cycles",
                     obs_rv_len.size(), (obs_rv_len.size() > 0) ? obs_rv_len[0] : -1);
        end
        tests_run++;
        if (obs_req.size() != 1 || obs_req[0] !== 32'h1A_04_03_02 || !obs_req_stable) begin
            tests_failed++;
            $display("[TB] FAIL single_req_data: got %h stable=%0b expected 1a040302 stable",
                     (obs_req.size() > 0) ? obs_req[0] : 32'hx, obs_req_stable);
        end
        tests_run++;
        if (obs_res_idx.size() != 1 || obs_res_idx[0] != 0 || obs_res_data[0] !== 8'h1A) begin
            tests_failed++;
            $display("[TB] FAIL single_result: count=%0d idx=%0d data=%h expected 1 result idx 0 data 1a",
                     obs_res_idx.size(), (obs_res_idx.size() > 0) ? obs_res_idx[0] : -1,
                     (obs_res_data.size() > 0) ? obs_res_data[0] : 8'hx);
        end
        tests_run++;
        if (obs_done != 1 || obs_err_at_done !== 4'd0 || obs_busy_after !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_done: done_cycles=%0d err_cnt=%0d busy_after=%0b expected 1, 0, 0",
                     obs_done, obs_err_at_done, obs_busy_after);
        end
    endtask

    task automatic test_multi_job;
        int exp_err;
        for (int i = 0; i < 4; i++) begin
            load(3'(i), {8'h10 + 8'(i), 24'h0});
            rsp_tab[i] = 8'h10 + 8'(i);
        end
        rsp_tab[2] = 8'hFF;
`ifdef MAC_ISSUER_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        run_jobs(4, 1'b1);
        tests_run++;
        if (obs_finished !== 1'b1 || obs_res_idx.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL multi_count: finished=%0b results=%0d expected 1 and 4", obs_finished, obs_res_idx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (obs_res_idx[i] != i || obs_res_data[i] !== rsp_tab[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL multi_result %0d: idx=%0d data=%h expected idx %0d data %h",
                             i, obs_res_idx[i], obs_res_data[i], i, rsp_tab[i]);
                end
            end
        end
        tests_run++;
        if (obs_req.size() != 4 || obs_req[3] !== 32'h13_00_00_00 || !obs_req_stable) begin
            tests_failed++;
            $display("[TB] FAIL multi_req: issues=%0d last=%h expected 4 issues last 13000000",
                     obs_req.size(), (obs_req.size() > 0) ? obs_req[obs_req.size()-1] : 32'hx);
        end
        tests_run++;
        if (obs_min_gap < 2) begin
            tests_failed++;
            $display("[TB] FAIL multi_gap: min capture-to-issue cycles=%0d expected at least 2", obs_min_gap);
        end
        tests_run++;
        if (obs_done != 1 || int'(obs_err_at_done) != exp_err) begin
            tests_failed++;
            $display("[TB] FAIL multi_err_cnt: done_cycles=%0d err_cnt=%0d expected 1 and %0d",
                     obs_done, obs_err_at_done, exp_err);
        end
    endtask

    task automatic test_timeout;
        load(3'd0, 32'h00_00_00_05);
        run_jobs(1, 1'b0);
        tests_run++;
        if (obs_finished !== 1'b1 || obs_timeout !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_flag: finished=%0b timeout_err=%0b expected 1 and 1", obs_finished, obs_timeout);
        end
        tests_run++;
        if (obs_timeout_wait != 64) begin
            tests_failed++;
            $display("[TB] FAIL timeout_cycles: got %0d wait cycles expected 64", obs_timeout_wait);
        end
        tests_run++;
        if (obs_res_idx.size() != 0 || obs_done != 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_abort: results=%0d done_cycles=%0d expected 0 and 1", obs_res_idx.size(), obs_done);
        end
        rsp_tab[0] = 8'h00;
        run_jobs(1, 1'b1);
        tests_run++;
        if (obs_tv_at_issue !== 1'b0 || obs_timeout !== 1'b0 || obs_res_idx.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_clear: err_at_issue=%0b err_at_done=%0b results=%0d expected 0, 0, 1",
                     obs_tv_at_issue, obs_timeout, obs_res_idx.size());
        end
    endtask

    task automatic test_zero_jobs;
        run_jobs(0, 1'b1);
        tests_run++;
        if (obs_finished !== 1'b1 || obs_done != 1 || obs_done_cyc < 0 || obs_done_cyc > 1) begin
            tests_failed++;
            $display("[TB] FAIL zero_jobs_done: finished=%0b done_cycles=%0d done_at=%0d expected 1, 1, within 2 cycles",
                     obs_finished, obs_done, obs_done_cyc);
        end
        tests_run++;
        if (obs_rv_len.size() != 0 || obs_busy_after !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_jobs_issue: issues=%0d busy_after=%0b expected 0 and 0", obs_rv_len.size(), obs_busy_after);
        end
    endtask

    task automatic test_load_while_busy;
        load(3'd0, 32'hAA_00_00_01);
        rsp_tab[0] = 8'hAA;
        busy_load_data = 32'h55_00_00_02;
        busy_load = 1'b1;
        run_jobs(1, 1'b1);
        busy_load = 1'b0;
        run_jobs(1, 1'b1);
        tests_run++;
        if (obs_finished !== 1'b1 || obs_req.size() != 1 || obs_req[0] !== 32'hAA_00_00_01) begin
            tests_failed++;
            $display("[TB] FAIL load_while_busy: finished=%0b rerun req=%h expected aa000001",
                     obs_finished, (obs_req.size() > 0) ? obs_req[0] : 32'hx);
        end
    endtask

    task automatic test_reset_in_wait;
        bit seen_rv;
        int wait_cycles;
        int dones;
        seen_rv = 1'b0;
        wait_cycles = 0;
        dones = 0;
        num_jobs = 4'd1;
        start = 1'b1;
        for (int cyc = 0; cyc < 30 && wait_cycles < 5; cyc++) begin
            @(negedge clk);
            if (busy) start = 1'b0;
            if (r_valid) seen_rv = 1'b1;
            else if (seen_rv) wait_cycles++;
        end
        start = 1'b0;
        tests_run++;
        if (wait_cycles != 5 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_wait_reach: wait_cycles=%0d busy=%0b expected 5 and 1", wait_cycles, busy);
        end
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || r_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wait_async: busy=%0b r_valid=%0b expected 0 and 0", busy, r_valid);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy || r_valid) dones++;
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wait_quiet: %0d cycles with done/busy/r_valid after reset expected 0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_multi_job();
        test_timeout();
        test_zero_jobs();
        test_load_while_busy();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
